// File: rtl/icache_fetch_unit_if.sv
// Fetch and refill signal bundle for icache_fetch_unit.
//
// The bundle has two modports:
//   slave  - used by the cache. It receives fetch, flush and memory beats, and
//            drives instructions and refill requests.
//   master - used by the environment, meaning the fetch stage and instruction memory.
//
// Signals:
//   fetchValid_i / fetchAddress_i / fetchReady_o : fetch request handshake
//   flush_i                                      : invalidate the whole cache
//   instrValid_o / instr_o / instrAddress_o      : returned instruction (1-cycle pulse)
//   memReq_o / memAddress_o / memAck_i           : line refill request handshake
//   memData_i / memDataValid_i                   : refill beats
interface icache_fetch_unit_if #(
    parameter int addressSize    = 64,
    parameter int i_DatabusWidth = 32
);
    logic                       fetchValid_i;
    logic [0:addressSize-1]     fetchAddress_i;
    logic                       fetchReady_o;
    logic                       flush_i;
    logic                       instrValid_o;
    logic [0:31]                instr_o;
    logic [0:addressSize-1]     instrAddress_o;
    logic                       memReq_o;
    logic [0:addressSize-1]     memAddress_o;
    logic                       memAck_i;
    logic [0:i_DatabusWidth-1]  memData_i;
    logic                       memDataValid_i;

    modport slave (
        input  fetchValid_i, fetchAddress_i, flush_i,
        input  memAck_i, memData_i, memDataValid_i,
        output fetchReady_o, instrValid_o, instr_o, instrAddress_o,
        output memReq_o, memAddress_o
    );

    modport master (
        output fetchValid_i, fetchAddress_i, flush_i,
        output memAck_i, memData_i, memDataValid_i,
        input  fetchReady_o, instrValid_o, instr_o, instrAddress_o,
        input  memReq_o, memAddress_o
    );
endinterface

// File: rtl/icache_fetch_unit.sv
// Direct-mapped, read-only instruction cache. It has a line-refill state machine.
//
// A hit returns the addressed 32-bit instruction one cycle after the request is
// accepted. A miss requests the line-aligned address from instruction memory and
// fills the whole line beat by beat. It then returns the requested word one cycle
// after the last beat. The requested word is forwarded from the incoming beat when
// that beat carries it. All vectors are numbered big-endian: bit 0 is the MSB.
//
// Ports:
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset
//   bus     : icache_fetch_unit_if.slave. This carries the fetch handshake, flush,
//             the instruction return, and the refill request and beat interface.
module icache_fetch_unit #(
    parameter int addressSize      = 64,
    parameter int i_DatabusWidth   = 32,
    parameter int iCacheOffsetSize = 5,
    parameter int iCacheIndexSize  = 6
) (
    input  logic                clock_i,
    input  logic                reset_i,
    icache_fetch_unit_if.slave  bus
);
    localparam int TAG_W     = addressSize - iCacheOffsetSize - iCacheIndexSize;
    localparam int LINE_BITS = (2 ** iCacheOffsetSize) * 8;
    localparam int BEATS     = LINE_BITS / i_DatabusWidth;
    localparam int LINES     = 2 ** iCacheIndexSize;
    localparam int WORD_W    = iCacheOffsetSize - 2;
    localparam int WPB       = i_DatabusWidth / 32;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_POS  = addressSize - iCacheOffsetSize;

    localparam logic [0:CNT_W-1]       LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [0:addressSize-1] LINE_MASK =
        {{(addressSize - iCacheOffsetSize){1'b1}}, {iCacheOffsetSize{1'b0}}};
    localparam logic [0:addressSize-1] WORD_MASK = {{(addressSize - 2){1'b1}}, 2'b00};

    typedef enum logic [0:1] {IDLE, REQ, FILL} state_t;

    logic [0:LINE_BITS-1] data_mem [LINES];
    logic [0:TAG_W-1]     tag_mem  [LINES];
    logic [0:LINES-1]     valid_bits;

    state_t                 state, state_nxt;
    logic [0:addressSize-1] lat_addr;
    logic [0:CNT_W-1]       beat_cnt;
    logic                   flush_pend;

    // Fields of the incoming fetch address, used for the hit lookup.
    logic [0:iCacheIndexSize-1] f_idx;
    logic [0:TAG_W-1]           f_tag;
    logic [0:WORD_W-1]          f_word;
    logic [0:LINE_BITS-1]       f_line;
    logic [0:31]                f_instr;
    logic                       f_hit;
    int                         f_word_bit;

    assign f_idx      = bus.fetchAddress_i[TAG_W +: iCacheIndexSize];
    assign f_tag      = bus.fetchAddress_i[0 +: TAG_W];
    assign f_word     = bus.fetchAddress_i[WORD_POS +: WORD_W];
    assign f_line     = data_mem[f_idx];
    assign f_word_bit = 32 * int'(f_word);
    assign f_instr    = f_line[f_word_bit +: 32];
    assign f_hit      = valid_bits[f_idx] && (tag_mem[f_idx] == f_tag);

    // Fields of the latched miss address, used during the refill.
    logic [0:iCacheIndexSize-1] l_idx;
    logic [0:TAG_W-1]           l_tag;
    logic [0:WORD_W-1]          l_word;
    logic [0:LINE_BITS-1]       l_line;
    logic [0:CNT_W-1]           l_beat;
    logic [0:31]                fill_instr;
    int                         l_word_bit;
    int                         l_lane_bit;

    assign l_idx      = lat_addr[TAG_W +: iCacheIndexSize];
    assign l_tag      = lat_addr[0 +: TAG_W];
    assign l_word     = lat_addr[WORD_POS +: WORD_W];
    assign l_line     = data_mem[l_idx];
    assign l_word_bit = 32 * int'(l_word);
    assign l_lane_bit = 32 * (int'(l_word) % WPB);
    assign l_beat     = CNT_W'(int'(l_word) / WPB);
    // On the last beat, the array does not yet hold this beat. So the requested
    // word comes from the bus when it lives in the beat now arriving.
    assign fill_instr = (beat_cnt == l_beat) ? bus.memData_i[l_lane_bit +: 32]
                                             : l_line[l_word_bit +: 32];

    logic fetch_ready, hit_acc, miss_acc, req_done, beat_we, fill_done;

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        hit_acc     = 1'b0;
        miss_acc    = 1'b0;
        req_done    = 1'b0;
        beat_we     = 1'b0;
        fill_done   = 1'b0;
        case (state)
            IDLE: begin
                fetch_ready = !bus.flush_i;
                if (bus.fetchValid_i && fetch_ready) begin
                    if (f_hit) begin
                        hit_acc = 1'b1;
                    end else begin
                        miss_acc  = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.memAck_i) begin
                    req_done  = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (bus.memDataValid_i) begin
                    beat_we = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        fill_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fetchReady_o = fetch_ready;

    // Control and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_bits         <= '0;
            beat_cnt           <= '0;
            flush_pend         <= 1'b0;
            bus.instrValid_o   <= 1'b0;
            bus.instr_o        <= '0;
            bus.instrAddress_o <= '0;
            bus.memReq_o       <= 1'b0;
            bus.memAddress_o   <= '0;
        end else begin
            bus.instrValid_o <= hit_acc || fill_done;
            if (hit_acc) begin
                bus.instr_o        <= f_instr;
                bus.instrAddress_o <= bus.fetchAddress_i & WORD_MASK;
            end
            if (fill_done) begin
                bus.instr_o        <= fill_instr;
                bus.instrAddress_o <= lat_addr & WORD_MASK;
            end
            if (miss_acc) begin
                bus.memReq_o     <= 1'b1;
                bus.memAddress_o <= bus.fetchAddress_i & LINE_MASK;
                beat_cnt         <= '0;
                flush_pend       <= 1'b0;
            end else if (bus.flush_i && state != IDLE) begin
                // A flush during a refill leaves the refilled line invalid.
                flush_pend <= 1'b1;
            end
            if (req_done) bus.memReq_o <= 1'b0;
            if (beat_we)  beat_cnt <= beat_cnt + CNT_W'(1);
            if (bus.flush_i) begin
                valid_bits <= '0;
            end else begin
                // The victim line is invalidated up front. This stops a refill
                // that is later abandoned from leaving a half-overwritten line
                // that still looks valid.
                if (miss_acc)                  valid_bits[f_idx] <= 1'b0;
                if (fill_done && !flush_pend)  valid_bits[l_idx] <= 1'b1;
            end
        end
    end

    // Data-side storage. It is not reset; the valid bits guard its contents.
    always_ff @(posedge clock_i) begin
        if (miss_acc) lat_addr <= bus.fetchAddress_i;
        if (beat_we)
            data_mem[l_idx][int'(beat_cnt) * i_DatabusWidth +: i_DatabusWidth] <= bus.memData_i;
        if (fill_done) tag_mem[l_idx] <= l_tag;
    end
endmodule

// File: tb/tb_icache_fetch_unit.sv
module tb_icache_fetch_unit;
    localparam int LINES = 64;
    localparam int BPL   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_fetch_unit_if bus ();

    icache_fetch_unit dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It tracks cache contents as words per line and an
    // outstanding refill as a transaction. Expected registered outputs are
    // updated at each rising edge.
    bit          mv [LINES];
    logic [63:0] mt [LINES];
    logic [31:0] md [LINES][BPL];
    bit          m_busy, m_acked, m_flushed, model_live;
    int          m_beats, m_idx, m_word;
    logic [63:0] m_addr, m_tag;
    logic        e_valid, e_req;
    logic [31:0] e_instr;
    logic [63:0] e_iaddr, e_maddr;

    logic [63:0] s_a;
    logic [31:0] s_d;
    int          s_idx, s_w;

    initial begin
        m_busy = 0; model_live = 0;
        e_valid = 0; e_req = 0; e_instr = 0; e_iaddr = 0; e_maddr = 0;
    end

    always @(posedge clk) begin
        model_live = 1;
        s_a = bus.fetchAddress_i;
        s_d = bus.memData_i;
        if (rst) begin
            m_busy = 0;
            for (int i = 0; i < LINES; i++) mv[i] = 0;
            e_valid = 0; e_instr = 0; e_iaddr = 0; e_req = 0; e_maddr = 0;
        end else begin
            e_valid = 0;
            if (!m_busy) begin
                if (bus.flush_i) begin
                    for (int i = 0; i < LINES; i++) mv[i] = 0;
                end else if (bus.fetchValid_i) begin
                    s_idx = int'(s_a[10:5]);
                    s_w   = int'(s_a[4:2]);
                    if (mv[s_idx] && mt[s_idx] == (s_a >> 11)) begin
                        e_valid = 1;
                        e_instr = md[s_idx][s_w];
                        e_iaddr = {s_a[63:2], 2'b00};
                    end else begin
                        m_busy = 1; m_acked = 0; m_flushed = 0; m_beats = 0;
                        m_addr = s_a; m_idx = s_idx; m_word = s_w; m_tag = s_a >> 11;
                        mv[s_idx] = 0;
                        e_req = 1;
                        e_maddr = {s_a[63:5], 5'b00000};
                    end
                end
            end else begin
                if (bus.flush_i) begin
                    for (int i = 0; i < LINES; i++) mv[i] = 0;
                    m_flushed = 1;
                end
                if (!m_acked) begin
                    if (bus.memAck_i) begin
                        m_acked = 1;
                        e_req = 0;
                    end
                end else if (bus.memDataValid_i) begin
                    md[m_idx][m_beats] = s_d;
                    m_beats++;
                    if (m_beats == BPL) begin
                        m_busy = 0;
                        if (!m_flushed) begin
                            mv[m_idx] = 1;
                            mt[m_idx] = m_tag;
                        end
                        e_valid = 1;
                        e_instr = md[m_idx][m_word];
                        e_iaddr = {m_addr[63:2], 2'b00};
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("instrValid", bus.instrValid_o, e_valid);
            check("instr", bus.instr_o, e_instr);
            check("instrAddress", bus.instrAddress_o, e_iaddr);
            check("memReq", bus.memReq_o, e_req);
            check("memAddress", bus.memAddress_o, e_maddr);
            check("fetchReady", bus.fetchReady_o, !m_busy && !bus.flush_i);
        end
    end

    // Random memory responder, enabled only in the randomized phase.
    bit auto_mem = 0;
    always begin
        @(posedge clk);
        #1;
        if (auto_mem) begin
            bus.memAck_i       = ($urandom % 3 == 0);
            bus.memDataValid_i = ($urandom % 2 == 1);
            bus.memData_i      = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] base, input int flush_beat, input int rst_beat);
        int n;
        n = 0;
        while (!bus.memReq_o && n < 100) begin
            tick();
            n++;
        end
        check("refill_req_seen", bus.memReq_o, 1);
        bus.memAck_i = 1;
        tick();
        bus.memAck_i = 0;
        for (int k = 0; k < BPL; k++) begin
            if ($urandom % 2 == 1) tick();
            bus.memDataValid_i = 1;
            bus.memData_i      = base + 32'(k);
            if (k == flush_beat) bus.flush_i = 1;
            if (k == rst_beat)   rst = 1;
            tick();
            bus.memDataValid_i = 0;
            bus.flush_i        = 0;
            if (k == rst_beat) begin
                rst = 0;
                return;
            end
        end
    endtask

    task automatic fetch_one(input logic [63:0] addr);
        bus.fetchValid_i   = 1;
        bus.fetchAddress_i = addr;
        tick();
        bus.fetchValid_i = 0;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] t;
        int s;
        s = int'($urandom % 4);
        t = (s == 3) ? 64'h001F_FFFF_FFFF_FFFF : 64'(s);
        return (t << 11) | (64'($urandom % 4) << 5) | 64'($urandom % 32);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fetchValid_i = 0; bus.fetchAddress_i = '0; bus.flush_i = 0;
        bus.memAck_i = 0; bus.memData_i = '0; bus.memDataValid_i = 0;
        tick();
        tick();
        check("reset_instrValid", bus.instrValid_o, 0);
        check("reset_memReq", bus.memReq_o, 0);
        check("reset_memAddress", bus.memAddress_o, 0);
        check("reset_instr", bus.instr_o, 0);
        check("reset_fetchReady", bus.fetchReady_o, 1);
        rst = 0;

        // Cold miss
        fetch_one(64'h1004);
        check("cold_memReq", bus.memReq_o, 1);
        check("cold_memAddress", bus.memAddress_o, 64'h1000);
        check("cold_fetchReady", bus.fetchReady_o, 0);
        refill(32'hA000_0000, -1, -1);
        check("cold_valid", bus.instrValid_o, 1);
        check("cold_instr", bus.instr_o, 32'hA000_0001);
        check("cold_iaddr", bus.instrAddress_o, 64'h1004);
        check("cold_ready", bus.fetchReady_o, 1);
        check("model_cold_instr", e_instr, 32'hA000_0001);

        // Hit stream
        bus.fetchValid_i = 1;
        bus.fetchAddress_i = 64'h1000;
        tick();
        check("hit0_valid", bus.instrValid_o, 1);
        check("hit0_instr", bus.instr_o, 32'hA000_0000);
        bus.fetchAddress_i = 64'h1008;
        tick();
        check("hit1_valid", bus.instrValid_o, 1);
        check("hit1_instr", bus.instr_o, 32'hA000_0002);
        bus.fetchAddress_i = 64'h101C;
        tick();
        check("hit2_valid", bus.instrValid_o, 1);
        check("hit2_instr", bus.instr_o, 32'hA000_0007);
        check("hit2_iaddr", bus.instrAddress_o, 64'h101C);
        check("hit_no_req", bus.memReq_o, 0);
        check("model_hit2_instr", e_instr, 32'hA000_0007);
        bus.fetchValid_i = 0;
        tick();
        check("hit_end_valid", bus.instrValid_o, 0);

        // Conflict eviction
        fetch_one(64'h1800);
        check("conflict_req", bus.memReq_o, 1);
        check("conflict_maddr", bus.memAddress_o, 64'h1800);
        refill(32'hB000_0000, -1, -1);
        check("conflict_instr", bus.instr_o, 32'hB000_0000);
        fetch_one(64'h1000);
        check("conflict_remiss", bus.memReq_o, 1);
        refill(32'hA100_0000, -1, -1);
        check("conflict_reinstr", bus.instr_o, 32'hA100_0000);

        // Flush mid-refill
        fetch_one(64'h2348);
        refill(32'hC000_0000, 3, -1);
        check("flushmid_valid", bus.instrValid_o, 1);
        check("flushmid_instr", bus.instr_o, 32'hC000_0002);
        check("flushmid_iaddr", bus.instrAddress_o, 64'h2348);
        fetch_one(64'h2348);
        check("flushmid_remiss", bus.memReq_o, 1);
        refill(32'hC100_0000, -1, -1);
        check("flushmid_reinstr", bus.instr_o, 32'hC100_0002);

        // Reset mid-refill
        fetch_one(64'h3010);
        refill(32'hD000_0000, -1, 4);
        check("rstmid_valid", bus.instrValid_o, 0);
        check("rstmid_instr", bus.instr_o, 0);
        check("rstmid_iaddr", bus.instrAddress_o, 0);
        check("rstmid_req", bus.memReq_o, 0);
        check("rstmid_maddr", bus.memAddress_o, 0);
        check("rstmid_ready", bus.fetchReady_o, 1);
        tick();
        check("rstmid_novalid", bus.instrValid_o, 0);
        fetch_one(64'h3010);
        check("rstmid_remiss", bus.memReq_o, 1);
        refill(32'hD100_0000, -1, -1);
        check("rstmid_reinstr", bus.instr_o, 32'hD100_0004);

        // Flush versus fetch (0x3010 is resident at this point)
        bus.fetchValid_i = 1;
        bus.fetchAddress_i = 64'h3010;
        bus.flush_i = 1;
        #1;
        check("flushfetch_ready", bus.fetchReady_o, 0);
        tick();
        bus.fetchValid_i = 0;
        bus.flush_i = 0;
        check("flushfetch_novalid", bus.instrValid_o, 0);
        check("flushfetch_noreq", bus.memReq_o, 0);
        fetch_one(64'h3010);
        check("flushfetch_remiss", bus.memReq_o, 1);
        refill(32'hE000_0000, -1, -1);
        check("flushfetch_reinstr", bus.instr_o, 32'hE000_0004);

        // Randomized traffic against the model
        auto_mem = 1;
        for (int i = 0; i < 3000; i++) begin
            bus.fetchValid_i   = ($urandom % 4 != 0);
            bus.fetchAddress_i = rand_addr();
            bus.flush_i        = ($urandom % 40 == 0);
            rst                = ($urandom % 300 == 0);
            tick();
        end
        auto_mem = 0;
        rst = 0;
        bus.fetchValid_i = 0; bus.flush_i = 0;
        bus.memAck_i = 0; bus.memDataValid_i = 0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_fetch_unit.md
# icache_fetch_unit

Parametrised instruction-fetch front end for the PowerISA core: a direct-mapped, read-only instruction cache with a refill state machine that fills whole lines from instruction memory over a narrow beat bus. The fetch stage presents a fetch address. The block returns one 32-bit instruction per hit per cycle, and stalls the fetch stage for the duration of a line refill on a miss. It replaces the core's raw I-memory port with a cached, handshaked interface. Cache geometry and bus width are generics.

## Interface
- `addressSize`, 64: fetch/memory address width.
- `i_DatabusWidth`, 32: refill beat width in bits; must be a multiple of 32.
- `iCacheOffsetSize`, 5: log2 of line size in bytes. Line is 32 B.
- `iCacheIndexSize`, 6: log2 of line count. 64 lines.
- Derived values:
  - tag width = `addressSize − iCacheOffsetSize − iCacheIndexSize`.
  - beats per line = (2^`iCacheOffsetSize` × 8) / `i_DatabusWidth`.
- Bit numbering is big-endian on every vector ([0:N-1], bit 0 is the MSB).

Ports:
- `clock_i` in 1: sole clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `fetchValid_i` in 1: fetch request.
- `fetchAddress_i` in `addressSize`: byte address of the instruction. The two LSBs are ignored.
- `fetchReady_o` out 1: block can accept a request this cycle.
- `flush_i` in 1: invalidate the whole cache.
- `instrValid_o` out 1: one-cycle pulse; `instr_o` and `instrAddress_o` are valid.
- `instr_o` out 32: instruction. Byte at the lowest address goes to bits [0:7].
- `instrAddress_o` out `addressSize`: address of the returned instruction, with the two LSBs forced to 0.
- `memReq_o` out 1: refill request.
- `memAddress_o` out `addressSize`: line-aligned refill address.
- `memAck_i` in 1: memory accepted the request.
- `memData_i` in `i_DatabusWidth`: refill beat.
- `memDataValid_i` in 1: beat present on `memData_i`.

## Operation
- Storage per line: valid bit, tag, data.
- Address fields, LSB-side:
  - offset: low `iCacheOffsetSize` bits.
  - index: next `iCacheIndexSize` bits.
  - tag: the remaining bits.
- Word select: offset bits excluding the two LSBs.
- States: IDLE, REQ, FILL.
- IDLE:
  - `fetchReady_o` = 1 unless `flush_i` is high.
  - A request is accepted when `fetchValid_i && fetchReady_o`. The block latches the address, then compares the tag and valid bit combinationally.
  - Hit: the registered instruction pulses on the next cycle. State stays IDLE.
  - Miss: go to REQ.
- REQ:
  - `memReq_o` = 1 and `memAddress_o` = latched address with the offset bits zeroed.
  - Both are held stable until `memAck_i`, then go to FILL with the beat counter at 0.
  - `memDataValid_i` is ignored in REQ.
- FILL:
  - Each `memDataValid_i` writes beat k to bytes k×(`i_DatabusWidth`/8) and upward of the indexed line. Beat 0 is the lowest address.
  - On the last beat: write the tag, set the valid bit, load `instr_o` with the requested word (forwarded from the incoming beat if that beat contains it), and go to IDLE.
  - Beats after the last one are ignored.
- A miss always overwrites the indexed line (conflict eviction).
- Flush:
  - `flush_i` clears all valid bits in one cycle and takes priority over a same-cycle fetch; that fetch is not accepted.
  - Flush during REQ or FILL: the refill completes and the instruction is returned, but the line is left invalid.
- Reset:
  - State goes to IDLE, all valid bits clear, beat counter clears.
  - Outputs reset to: `instrValid_o`=0, `instr_o`=0, `instrAddress_o`=0, `memReq_o`=0, `memAddress_o`=0.
  - `fetchReady_o`=1 from the first cycle after reset.
  - Reset mid-refill abandons the refill: no valid bit is set and no instruction is returned.
- Data array contents are not reset.

## Timing
- Hit latency: accept at cycle N, `instrValid_o` pulses at N+1. Throughput is one hit per cycle with back-to-back requests.
- Miss:
  - Accept at cycle N.
  - `memReq_o` rises at N+1 and stays high through the cycle in which `memAck_i` is seen.
  - FILL starts the cycle after the ack.
  - Last beat arrives at cycle L; `instrValid_o` pulses at L+1 with `fetchReady_o`=1.
- `fetchReady_o` = 0 from N+1 through L.
- `memAck_i` may already be high in the first REQ cycle; memory beats may arrive with gaps.
- `instrValid_o` is never high for more than one cycle per accepted request.

## Test plan
- **Cold miss.** Reset, then fetch 0x1004 with defaults. Expect `memReq_o` with `memAddress_o`=0x1000. Ack, then send 8 beats 0xA0000000+k. Expect `instr_o`=0xA0000001 and `instrAddress_o`=0x1004 one cycle after beat 7.
- **Hit stream.** After the cold miss, fetch 0x1000, 0x1008 and 0x101C on consecutive cycles. Expect three consecutive `instrValid_o` pulses carrying 0xA0000000, 0xA0000002 and 0xA0000007, with no `memReq_o`.
- **Conflict.** Fetch 0x1800, which has the same index and a different tag. Expect a refill. A later fetch of 0x1000 misses again.
- **Flush mid-refill.** Assert `flush_i` during FILL at beat 3. Expect the instruction to be returned. A refetch of the same address misses.
- **Reset mid-refill.** Assert `reset_i` at beat 4. Expect all outputs to be 0 the next cycle, no `instrValid_o`, and `fetchReady_o`=1. A refetch misses.
- **Flush vs fetch.** Assert `flush_i` and `fetchValid_i` in the same cycle. Expect `fetchReady_o`=0, the request not accepted, and no response.
